// File: rtl/irrigacao_pkg.sv
// Irrigation controller shared definitions.
// Holds the FSM state enumeration (its numeric codes are what the top drives
// on the estado port) and the default timing constants, in ticks.
package irrigacao_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ASP   = 3'd1,
        GOT   = 3'd2,
        PAUSA = 3'd3,
        ERRO  = 3'd4
    } state_t;

    localparam int DEF_T_MIN_ON  = 10;
    localparam int DEF_T_MAX_ON  = 60;
    localparam int DEF_T_PAUSA   = 5;
    localparam int DEF_T_FILL_MAX = 120;
    localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/sincronizador.sv
// Parameterized-width two-flop synchronizer for asynchronous inputs.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both flop stages
//   d     - asynchronous input bus
//   q     - synchronized output bus (two clk edges of latency)
module sincronizador #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/controle_irrigacao.sv
// Irrigation controller: chooses sprinkler (ASP) or drip (GOT) irrigation,
// bounds each run with minimum/maximum times, rests afterwards, and keeps the
// tank filled through a hysteresis-controlled inlet valve. Inconsistent level
// sensors or a fill that takes too long lock the controller in ERRO until
// acknowledged.
// Ports:
//   clk, rst_n      - system clock, asynchronous active-low reset
//   tick            - one-cycle time-base enable (already in clk domain)
//   H, M, L         - tank high/mid/low level sensors
//   Ua, Us, T       - air humidity ok, soil dry, temperature high
//   switch, rest    - system enable, error acknowledge
//   Vs, Bs, Ve      - sprinkler valve, drip pump, inlet valve
//   Erro, Alarme    - error state, alarm
//   estado          - current state code
module controle_irrigacao
    import irrigacao_pkg::*;
#(
    parameter int T_MIN_ON   = DEF_T_MIN_ON,
    parameter int T_MAX_ON   = DEF_T_MAX_ON,
    parameter int T_PAUSA    = DEF_T_PAUSA,
    parameter int T_FILL_MAX = DEF_T_FILL_MAX,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       H,
    input  logic       M,
    input  logic       L,
    input  logic       Ua,
    input  logic       Us,
    input  logic       T,
    input  logic       switch,
    input  logic       rest,
    output logic       Vs,
    output logic       Bs,
    output logic       Ve,
    output logic       Erro,
    output logic       Alarme,
    output logic [2:0] estado
);

    localparam logic [CNT_W-1:0] MIN_ON   = CNT_W'(T_MIN_ON);
    localparam logic [CNT_W-1:0] MAX_ON   = CNT_W'(T_MAX_ON);
    localparam logic [CNT_W-1:0] PAUSA_T  = CNT_W'(T_PAUSA);
    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(T_FILL_MAX);

    logic [7:0] raw_in;
    logic [7:0] sync_in;
    logic       h_s, m_s, l_s, ua_s, us_s, t_s, sw_s, rest_s;

    state_t           state_q, next_state;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] fill_cnt_q;
    logic             ve_q, ve_next;
    logic             fault, fill_timeout;

    assign raw_in = {rest, switch, T, Us, Ua, L, M, H};

    sincronizador #(.WIDTH(8)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_in),
        .q     (sync_in)
    );

    assign {rest_s, sw_s, t_s, us_s, ua_s, l_s, m_s, h_s} = sync_in;

    // A higher sensor wet while a lower one is dry is physically impossible.
    assign fault        = (h_s & ~m_s) | (m_s & ~l_s);
    assign fill_timeout = (fill_cnt_q == FILL_MAX);

    always_comb begin
        next_state = state_q;
        if (fault || fill_timeout) begin
            next_state = ERRO;
        end else begin
            case (state_q)
                IDLE: begin
                    // Mode is latched by the state itself, so later T/Ua
                    // changes cannot switch it mid-run.
                    if (sw_s && us_s && l_s)
                        next_state = (!t_s && ua_s) ? ASP : GOT;
                end
                ASP, GOT: begin
                    if (!sw_s || !l_s || ((timer_q >= MIN_ON) && !us_s) ||
                        (timer_q == MAX_ON))
                        next_state = PAUSA;
                end
                PAUSA: begin
                    if (timer_q == PAUSA_T)
                        next_state = IDLE;
                end
                ERRO: begin
                    // Fault/timeout already hold ERRO above; also wait for
                    // the fill timer to drain before leaving.
                    if (rest_s && (fill_cnt_q == '0))
                        next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Inlet valve hysteresis: set on low, clear on high, off while in error.
    always_comb begin
        ve_next = ve_q;
        if (next_state == ERRO)
            ve_next = 1'b0;
        else if (!l_s)
            ve_next = 1'b1;
        else if (h_s)
            ve_next = 1'b0;
    end

    // Outputs are registered from next-state values so they switch on the
    // same edge as the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            fill_cnt_q <= '0;
            ve_q       <= 1'b0;
            Vs         <= 1'b0;
            Bs         <= 1'b0;
            Erro       <= 1'b0;
            Alarme     <= 1'b0;
        end else begin
            state_q <= next_state;
            ve_q    <= ve_next;
            Vs      <= (next_state == ASP);
            Bs      <= (next_state == GOT);
            Erro    <= (next_state == ERRO);
            Alarme  <= (next_state == ERRO) | (~l_s & us_s & sw_s);

            // A tick on a transition edge is dropped by the clear.
            if (next_state != state_q)
                timer_q <= '0;
            else if (tick && (timer_q != '1))
                timer_q <= timer_q + CNT_W'(1);

            if (!ve_q)
                fill_cnt_q <= '0;
            else if (tick && (fill_cnt_q != '1))
                fill_cnt_q <= fill_cnt_q + CNT_W'(1);
        end
    end

    assign Ve     = ve_q;
    assign estado = state_q;

endmodule

// File: tb/tb_controle_irrigacao.sv
module tb_controle_irrigacao;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       H = 1'b1, M = 1'b1, L = 1'b1;
    logic       Ua = 1'b1, Us = 1'b1, T = 1'b0;
    logic       switch = 1'b1, rest = 1'b0;
    logic       Vs, Bs, Ve, Erro, Alarme;
    logic [2:0] estado;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    controle_irrigacao #(
        .T_MIN_ON   (3),
        .T_MAX_ON   (6),
        .T_PAUSA    (2),
        .T_FILL_MAX (10),
        .CNT_W      (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .H      (H),
        .M      (M),
        .L      (L),
        .Ua     (Ua),
        .Us     (Us),
        .T      (T),
        .switch (switch),
        .rest   (rest),
        .Vs     (Vs),
        .Bs     (Bs),
        .Ve     (Ve),
        .Erro   (Erro),
        .Alarme (Alarme),
        .estado (estado)
    );

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // One tick sampled on the next rising edge.
    task automatic tick_step();
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic test_reset();
        step(3);
        n_tests++;
        if ({Vs, Bs, Ve, Erro, Alarme} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000", {Vs, Bs, Ve, Erro, Alarme});
        end
        n_tests++;
        if (estado !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_estado: got %0d expected 0", estado);
        end
        @(negedge clk);
        rst_n = 1'b1;
        Us = 1'b0;
        step(4);
    endtask

    task automatic test_asp();
        H = 1; M = 1; L = 1; switch = 1; Ua = 1; T = 0; Us = 1;
        step(2);
        n_tests++;
        if (estado !== 3'd0) begin
            n_fail++;
            $display("FAIL asp_latency: got %0d expected 0", estado);
        end
        step(1);
        n_tests++;
        if (estado !== 3'd1 || Vs !== 1'b1 || Bs !== 1'b0 || Alarme !== 1'b0) begin
            n_fail++;
            $display("FAIL asp_enter: estado=%0d Vs=%b Bs=%b Alarme=%b expected 1 1 0 0", estado, Vs, Bs, Alarme);
        end
        tick_step();
        Us = 0;
        tick_step();
        tick_step();
        n_tests++;
        if (estado !== 3'd1) begin
            n_fail++;
            $display("FAIL asp_min_hold: got %0d expected 1", estado);
        end
        step(1);
        n_tests++;
        if (estado !== 3'd3 || Vs !== 1'b0) begin
            n_fail++;
            $display("FAIL asp_to_pausa: estado=%0d Vs=%b expected 3 0", estado, Vs);
        end
        tick_step();
        tick_step();
        n_tests++;
        if (estado !== 3'd3) begin
            n_fail++;
            $display("FAIL pausa_hold: got %0d expected 3", estado);
        end
        step(1);
        n_tests++;
        if (estado !== 3'd0) begin
            n_fail++;
            $display("FAIL pausa_to_idle: got %0d expected 0", estado);
        end
    endtask

    task automatic test_got_max();
        T = 1; Us = 1;
        step(3);
        n_tests++;
        if (estado !== 3'd2 || Bs !== 1'b1 || Vs !== 1'b0) begin
            n_fail++;
            $display("FAIL got_enter: estado=%0d Bs=%b Vs=%b expected 2 1 0", estado, Bs, Vs);
        end
        for (int i = 1; i <= 6; i++) begin
            tick_step();
            n_tests++;
            if (estado !== 3'd2 || Bs !== 1'b1 || Vs !== 1'b0) begin
                n_fail++;
                $display("FAIL got_run_%0d: estado=%0d Bs=%b Vs=%b expected 2 1 0", i, estado, Bs, Vs);
            end
        end
        step(1);
        n_tests++;
        if (estado !== 3'd3 || Bs !== 1'b0 || Vs !== 1'b0) begin
            n_fail++;
            $display("FAIL got_max_cut: estado=%0d Bs=%b Vs=%b expected 3 0 0", estado, Bs, Vs);
        end
        T = 0; Us = 0;
        tick_step();
        tick_step();
        step(1);
        n_tests++;
        if (estado !== 3'd0) begin
            n_fail++;
            $display("FAIL got_back_idle: got %0d expected 0", estado);
        end
    endtask

    task automatic test_fill();
        T = 0; Ua = 1; Us = 1;
        step(3);
        n_tests++;
        if (estado !== 3'd1) begin
            n_fail++;
            $display("FAIL fill_asp: got %0d expected 1", estado);
        end
        H = 0; M = 0; L = 0;
        step(3);
        n_tests++;
        if (estado !== 3'd3 || Ve !== 1'b1 || Alarme !== 1'b1 || Vs !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_low: estado=%0d Ve=%b Alarme=%b Vs=%b expected 3 1 1 0", estado, Ve, Alarme, Vs);
        end
        Us = 0; L = 1;
        tick_step();
        M = 1;
        tick_step();
        H = 1;
        step(2);
        n_tests++;
        if (Ve !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_hold: Ve=%b expected 1", Ve);
        end
        step(1);
        n_tests++;
        if (Ve !== 1'b0 || estado !== 3'd0 || Alarme !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_done: Ve=%b estado=%0d Alarme=%b expected 0 0 0", Ve, estado, Alarme);
        end
    endtask

    task automatic test_fill_timeout();
        H = 0; M = 0; L = 0;
        step(3);
        n_tests++;
        if (Ve !== 1'b1 || Erro !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_fill_on: Ve=%b Erro=%b expected 1 0", Ve, Erro);
        end
        for (int i = 0; i < 10; i++) tick_step();
        n_tests++;
        if (estado !== 3'd0) begin
            n_fail++;
            $display("FAIL tmo_early: got %0d expected 0", estado);
        end
        step(1);
        n_tests++;
        if (estado !== 3'd4 || Erro !== 1'b1 || Ve !== 1'b0 || Alarme !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_erro: estado=%0d Erro=%b Ve=%b Alarme=%b expected 4 1 0 1", estado, Erro, Ve, Alarme);
        end
        H = 1; M = 1; L = 1;
        step(3);
        n_tests++;
        if (estado !== 3'd4) begin
            n_fail++;
            $display("FAIL tmo_no_ack: got %0d expected 4", estado);
        end
        rest = 1;
        step(2);
        n_tests++;
        if (estado !== 3'd4) begin
            n_fail++;
            $display("FAIL tmo_ack_latency: got %0d expected 4", estado);
        end
        step(1);
        rest = 0;
        n_tests++;
        if (estado !== 3'd0 || Erro !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_recover: estado=%0d Erro=%b expected 0 0", estado, Erro);
        end
        step(3);
    endtask

    task automatic test_fault();
        T = 1; Us = 1;
        step(3);
        n_tests++;
        if (estado !== 3'd2 || Bs !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_got: estado=%0d Bs=%b expected 2 1", estado, Bs);
        end
        M = 0;
        step(2);
        n_tests++;
        if (estado !== 3'd2) begin
            n_fail++;
            $display("FAIL fault_latency: got %0d expected 2", estado);
        end
        step(1);
        n_tests++;
        if (estado !== 3'd4 || Bs !== 1'b0 || Erro !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_erro: estado=%0d Bs=%b Erro=%b expected 4 0 1", estado, Bs, Erro);
        end
        rest = 1;
        step(4);
        rest = 0;
        n_tests++;
        if (estado !== 3'd4) begin
            n_fail++;
            $display("FAIL fault_persist: got %0d expected 4", estado);
        end
        Us = 0; T = 0; M = 1;
        step(3);
        rest = 1;
        step(3);
        rest = 0;
        n_tests++;
        if (estado !== 3'd0) begin
            n_fail++;
            $display("FAIL fault_clear: got %0d expected 0", estado);
        end
        step(3);
    endtask

    task automatic test_reset_mid();
        T = 0; Ua = 1; Us = 1;
        step(3);
        n_tests++;
        if (estado !== 3'd1 || Vs !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_asp: estado=%0d Vs=%b expected 1 1", estado, Vs);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (Vs !== 1'b0 || estado !== 3'd0) begin
            n_fail++;
            $display("FAIL rmid_async: Vs=%b estado=%0d expected 0 0", Vs, estado);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2);
        n_tests++;
        if (estado !== 3'd0) begin
            n_fail++;
            $display("FAIL rmid_latency: got %0d expected 0", estado);
        end
        step(1);
        n_tests++;
        if (estado !== 3'd1 || Vs !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_reenter: estado=%0d Vs=%b expected 1 1", estado, Vs);
        end
    endtask

    initial begin
        test_reset();
        test_asp();
        test_got_max();
        test_fill();
        test_fill_timeout();
        test_fault();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
